// File: rtl/time_set_controller.sv
// Pushbutton time-entry front end: debounces MODE/INC, edits HH:MM:SS field by field
// and emits a one-cycle load strobe. States: RUN idle | SET_H/M/S edit field | COMMIT load.
module time_set_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic [4:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic       load,
  output logic       setting,
  output logic [2:0] blink_mask
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BKW = $clog2(BLINK_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BKW-1:0] BK_LAST = BKW'(BLINK_CYCLES - 1);

  typedef enum logic [2:0] {RUN, SET_H, SET_M, SET_S, COMMIT} state_t;

  // Key index 0 = MODE, 1 = INC
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          lvl_q, lvl_d;
  logic [1:0][DBW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]          press;
  logic                mode_press, inc_press;

  state_t              state_q, state_d;
  logic [4:0]          hours_q, hours_d;
  logic [5:0]          minutes_q, minutes_d;
  logic [5:0]          seconds_q, seconds_d;
  logic [BKW-1:0]      blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      db_cnt_d[k] = '0;
      lvl_d[k]    = lvl_q[k];
      press[k]    = 1'b0;
      if (sync2_q[k] != lvl_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          lvl_d[k] = sync2_q[k];
          press[k] = lvl_q[k];  // only a released->pressed change is an event
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + DBW'(1);
        end
      end
    end
  end

  assign mode_press = press[0];
  assign inc_press  = press[1];

  always_comb begin
    state_d   = state_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    case (state_q)
      RUN: begin
        if (mode_press) begin
          state_d   = SET_H;
          hours_d   = cur_hours;
          minutes_d = cur_minutes;
          seconds_d = cur_seconds;
        end
      end
      SET_H: begin
        if (mode_press)     state_d = SET_M;
        else if (inc_press) hours_d = (hours_q >= 5'd23) ? 5'd0 : hours_q + 5'd1;
      end
      SET_M: begin
        if (mode_press)     state_d   = SET_S;
        else if (inc_press) minutes_d = (minutes_q >= 6'd59) ? 6'd0 : minutes_q + 6'd1;
      end
      SET_S: begin
        if (mode_press)     state_d   = COMMIT;
        else if (inc_press) seconds_d = 6'd0;
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Blink restarts visible on every state entry and INC press so the user sees the new value
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BKW'(1);
    blink_phase_d = blink_phase_q;
    if ((state_d != state_q) || inc_press) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 2'b11;
      sync2_q       <= 2'b11;
      lvl_q         <= 2'b11;
      db_cnt_q      <= '0;
      state_q       <= RUN;
      hours_q       <= '0;
      minutes_q     <= '0;
      seconds_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      sync1_q       <= {btn_inc, btn_mode};
      sync2_q       <= sync1_q;
      lvl_q         <= lvl_d;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      hours_q       <= hours_d;
      minutes_q     <= minutes_d;
      seconds_q     <= seconds_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign set_hours   = hours_q;
  assign set_minutes = minutes_q;
  assign set_seconds = seconds_q;
  assign load        = (state_q == COMMIT);
  assign setting     = (state_q != RUN);

  always_comb begin
    blink_mask = 3'b000;
    if (blink_phase_q) begin
      case (state_q)
        SET_H:   blink_mask = 3'b100;
        SET_M:   blink_mask = 3'b010;
        SET_S:   blink_mask = 3'b001;
        default: blink_mask = 3'b000;
      endcase
    end
  end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Pushbutton-driven time-entry front end for the 24-hour HH:MM:SS clock; the write side of the clock's time counters.
- Debounces two raw keys and steps through hour, minute and second edit fields.
- Emits a one-cycle load strobe with the new time for the clock counters to accept.
- Drives a per-field blink mask so the display path can flash the field being edited.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz)
BLINK_CYCLES, 12500000, cycles per blink phase toggle (2 Hz blink at 50 MHz)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset
btn_mode  input  1  raw MODE key, active-low, asynchronous to clk
btn_inc  input  1  raw INC key, active-low, asynchronous to clk
cur_hours  input  5  live clock hours, 0-23
cur_minutes  input  6  live clock minutes, 0-59
cur_seconds  input  6  live clock seconds, 0-59
set_hours  output  5  time value to load, hours
set_minutes  output  6  time value to load, minutes
set_seconds  output  6  time value to load, seconds
load  output  1  one-cycle strobe; clock counters take set_* when high
setting  output  1  high while editing; clock holds its counters
blink_mask  output  3  bit 2 = hours, bit 1 = minutes, bit 0 = seconds; 1 = blank that field

Behaviour:
- Reset (reset=0, asynchronous):
  - state RUN; edit registers, set_*, load, setting, blink_mask all 0.
  - Sync flops and debounced levels set to 1 (released); debounce and blink counters 0.
- Input conditioning, per key:
  - 2-FF synchronizer.
  - Debounce counter clears whenever the synced value equals the stable level.
  - Otherwise the counter increments; at DEBOUNCE_CYCLES-1 the stable level takes the synced value and the counter clears.
  - A press event is a one-cycle pulse on a stable 1->0 transition. Releases generate no event.
  - Raw edge to press pulse: 2 + DEBOUNCE_CYCLES cycles. Glitches shorter than DEBOUNCE_CYCLES produce no event.
- FSM states: RUN, SET_H, SET_M, SET_S, COMMIT.
  - RUN: MODE press -> copy cur_* into edit regs, go to SET_H. INC ignored.
  - SET_H: INC press -> hours+1; 23 wraps to 0, and any captured value >= 23 also wraps to 0. MODE press -> SET_M.
  - SET_M: INC press -> minutes+1; 59 wraps to 0 (>= 59 -> 0), no carry into hours. MODE press -> SET_S.
  - SET_S: INC press -> seconds cleared to 0. MODE press -> COMMIT.
  - COMMIT: exactly one cycle with load=1, then RUN unconditionally.
  - Key presses arriving in COMMIT are dropped.
- Simultaneous MODE and INC press in the same cycle: MODE wins; INC is discarded.
- Outputs:
  - set_* is registered and equals the edit regs at all times.
  - The state transition and the resulting edit-reg update take effect in the cycle after the press pulse.
  - setting = 1 in SET_H, SET_M, SET_S and COMMIT; 0 in RUN.
  - setting falls in the cycle after load.
- Blink:
  - A counter toggles blink_phase at BLINK_CYCLES-1.
  - Counter and phase (phase=0, field visible) restart on every state entry and on every INC press.
  - blink_mask = one-hot of the current field when blink_phase=1; 000 in RUN and COMMIT.
- Reset mid-edit: edit abandoned, no load issued, back to RUN.
- Key held down: one event only; no auto-repeat.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8):
1. Reset low, then high -> state RUN, load=0, setting=0, blink_mask=000, set_*=0.
2. cur = 12:34:56, MODE press -> 6 cycles after the raw edge: setting=1, set_* = 12:34:56, blink_mask toggles 000/100 every 8 cycles.
3. In SET_H with hours=23, INC press -> set_hours=0. MODE, then 3x INC from minutes=58 -> minutes 59, 0, 1; hours remain 0.
4. Full sequence MODE, INC, MODE, MODE, INC, MODE from 12:34:56 -> single load=1 pulse with set_* = 13:34:00, then setting=0 next cycle.
5. Raw 2-cycle low glitch on btn_inc in SET_H -> no increment. MODE and INC pulses aligned to the same cycle -> state advances, field unchanged.
6. Reset asserted in SET_M -> immediate RUN, setting=0, set_*=0, and no load pulse ever observed.
